vga_pattern_gen: RTL

Parametrised successor to the fixed 640x480 driver. Combines a pixel-enable divider, programmable H/V timing counters, sync generation and a multi-mode pattern generator in one block. Output is registered and aligned, with COLOR_W bits per channel. Sits between the board clock/reset and the VGA DAC/resistor pins; the board top instantiates it directly.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_timing.sv | 56 +++++
 rtl/vga_pattern_gen.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, mode encodings and the colour-bar table shared by vga_pattern_gen.
package vga_pkg;
  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_COLOR_W    = 1;
  localparam int DEF_SCROLL_DIV = 16;
`ifdef VGA_BORDER_EN
  localparam int DEF_BORDER_W   = 4;
`endif

  typedef enum logic [1:0] {
    MODE_SOLID  = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  // {R,G,B} per bar, bar 0 in the low bits: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_TABLE = {3'b000, 3'b001, 3'b100, 3'b101,
                                       3'b010, 3'b011, 3'b110, 3'b111};

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [2:0] bar_color(input logic [2:0] idx);
    return BAR_TABLE[3*idx +: 3];
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable divider, H/V raster counters and raw (unregistered) sync/active flags.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_ce,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       h_sync,
  output logic       v_sync,
  output logic       video_on,
  output logic       line_end,
  output logic       frame_end
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;

  // with CLK_DIV=1 div_cnt never leaves 0, so pix_ce is constantly high
  assign pix_ce    = div_cnt == DW'(CLK_DIV - 1);
  assign line_end  = h_cnt == 10'(H_TOTAL - 1);
  assign frame_end = line_end && v_cnt == 10'(V_TOTAL - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_ce ? '0 : div_cnt + 1'b1;
      if (pix_ce) begin
        h_cnt <= line_end ? '0 : h_cnt + 1'b1;
        if (line_end) v_cnt <= frame_end ? '0 : v_cnt + 1'b1;
      end
    end
  end

  assign h_sync   = (h_cnt >= 10'(H_ACTIVE + H_FP) && h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)) ? H_POL : ~H_POL;
  assign v_sync   = (v_cnt >= 10'(V_ACTIVE + V_FP) && v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)) ? V_POL : ~V_POL;
  assign video_on = h_cnt < 10'(H_ACTIVE) && v_cnt < 10'(V_ACTIVE);
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: parametrised VGA timing plus solid/bars/checker/scrolling-bar patterns, one registered output stage.
// Defining VGA_BORDER_EN adds a BORDER_W-pixel white frame around the active area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int   CLK_DIV    = DEF_CLK_DIV,
  parameter int   H_ACTIVE   = DEF_H_ACTIVE,
  parameter int   H_FP       = DEF_H_FP,
  parameter int   H_SYNC     = DEF_H_SYNC,
  parameter int   H_BP       = DEF_H_BP,
  parameter int   V_ACTIVE   = DEF_V_ACTIVE,
  parameter int   V_FP       = DEF_V_FP,
  parameter int   V_SYNC     = DEF_V_SYNC,
  parameter int   V_BP       = DEF_V_BP,
  parameter logic H_POL      = 1'b0,
  parameter logic V_POL      = 1'b0,
  parameter int   COLOR_W    = DEF_COLOR_W,
  parameter int   SCROLL_DIV = DEF_SCROLL_DIV
`ifdef VGA_BORDER_EN
  ,
  parameter int   BORDER_W   = DEF_BORDER_W
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode_sel,
  input  logic [3*COLOR_W-1:0] fg_color,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 video_on,
  output logic [9:0]           pixel_x,
  output logic [9:0]           pixel_y,
  output logic                 frame_start,
  output logic [1:0]           mode_active
);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int PW    = $clog2(BAR_W + 1);
  localparam int FW    = $clog2(SCROLL_DIV + 1);

  logic                 pix_ce, hs, vs, act, line_end, frame_end;
  logic [9:0]           h_cnt, v_cnt;
  logic [2:0]           bar_idx, scroll_off, bar_rgb;
  logic [PW-1:0]        bar_px;
  logic [FW-1:0]        frame_cnt;
  logic                 origin, h_act, bar_last;
  mode_e                mode_cur;
  logic [3*COLOR_W-1:0] bar_col, pat, col;

  vga_timing #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL   (H_POL),    .V_POL(V_POL)
  ) u_timing (
    .clk      (clk),
    .rst      (rst),
    .pix_ce   (pix_ce),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .h_sync   (hs),
    .v_sync   (vs),
    .video_on (act),
    .line_end (line_end),
    .frame_end(frame_end)
  );

  assign origin   = h_cnt == '0 && v_cnt == '0;
  assign h_act    = h_cnt < 10'(H_ACTIVE);
  assign bar_last = bar_px == PW'(BAR_W - 1);
  // the frame's first pixel already uses the newly requested mode
  assign mode_cur = mode_e'(origin ? mode_sel : mode_active);
  assign bar_rgb  = bar_color(mode_cur == MODE_SCROLL ? bar_idx + scroll_off : bar_idx);
  assign bar_col  = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};

  always_comb begin
    pat = mode_cur == MODE_SOLID ? fg_color :
          mode_cur == MODE_CHECK ? (h_cnt[5] ^ v_cnt[5] ? '0 : fg_color) : bar_col;
  end

`ifdef VGA_BORDER_EN
  logic border;
  assign border = h_cnt < 10'(BORDER_W) || h_cnt >= 10'(H_ACTIVE - BORDER_W) ||
                  v_cnt < 10'(BORDER_W) || v_cnt >= 10'(V_ACTIVE - BORDER_W);
  assign col = border ? '1 : pat;
`else
  assign col = pat;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bar_idx     <= '0;
      bar_px      <= '0;
      frame_cnt   <= '0;
      scroll_off  <= '0;
      mode_active <= '0;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && origin;
      if (pix_ce) begin
        // bar 7 absorbs the H_ACTIVE % 8 remainder by saturating
        if (line_end) begin
          bar_idx <= '0;
          bar_px  <= '0;
        end else if (h_act) begin
          bar_px <= bar_last ? '0 : bar_px + 1'b1;
          if (bar_last && bar_idx != 3'd7) bar_idx <= bar_idx + 1'b1;
        end
        if (frame_end) begin
          frame_cnt <= frame_cnt == FW'(SCROLL_DIV - 1) ? '0 : frame_cnt + 1'b1;
          if (frame_cnt == FW'(SCROLL_DIV - 1)) scroll_off <= scroll_off + 1'b1;
        end
        if (origin) mode_active <= mode_sel;
        h_sync               <= hs;
        v_sync               <= vs;
        video_on             <= act;
        pixel_x              <= h_cnt;
        pixel_y              <= v_cnt;
        {red, green, blue}   <= act ? col : '0;
      end
    end
  end
endmodule
